// File: rtl/pswd_update_pkg.sv
// Shared definitions for the password-store writer: FSM state encoding,
// failure codes, password/digit widths and the player-to-address mapping
// that the login checker also uses.
package pswd_update_pkg;

    localparam int DATA_W      = 24;
    localparam int DIG_W       = 4;
    localparam int ID_W        = 3;
    localparam int PSWD_ADDR_W = 5;

    localparam logic [1:0] ERR_GUEST    = 2'b01;
    localparam logic [1:0] ERR_MISMATCH = 2'b10;
    localparam logic [1:0] ERR_ABORT    = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_NEW_DIG  = 3'd1,
        S_CONF_DIG = 3'd2,
        S_COMPARE  = 3'd3,
        S_WRITE    = 3'd4,
        S_HOLD     = 3'd5,
        S_DONE     = 3'd6,
        S_REJECT   = 3'd7
    } state_e;

    // Password memory address of a player: zero-extended player ID.
    function automatic logic [PSWD_ADDR_W-1:0] pswd_addr(input logic [ID_W-1:0] id);
        return {2'b00, id};
    endfunction

    // True for a decimal digit 0..9.
    function automatic logic is_bcd(input logic [DIG_W-1:0] digit);
        return (digit <= 4'd9);
    endfunction

endpackage

// File: rtl/pswd_update_if.sv
// Signal bundle between the login side / password memory and pswd_update.
// master: environment (login FSM, keypad, memory); slave: pswd_update.
interface pswd_update_if
    import pswd_update_pkg::*;
#(
    parameter int ADDR_W = 5
) ();
    logic              LoggedIn;
    logic [ID_W-1:0]   PlayerID_internal;
    logic              isGuest;
    logic              change_req;
    logic              UserLoad;
    logic [DIG_W-1:0]  UserDigit;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              busy;
    logic              done;
    logic              err;
    logic [1:0]        err_code;

    modport master (
        output LoggedIn, PlayerID_internal, isGuest, change_req, UserLoad, UserDigit,
        input  wr_en, wr_addr, wr_data, busy, done, err, err_code
    );

    modport slave (
        input  LoggedIn, PlayerID_internal, isGuest, change_req, UserLoad, UserDigit,
        output wr_en, wr_addr, wr_data, busy, done, err, err_code
    );
endinterface

// File: rtl/pswd_digit_shift.sv
// Six-digit MSB-first password buffer. Non-decimal digits are dropped
// without advancing; full_o flags the strobe that completes the sixth digit,
// at which point the digit count wraps to zero while the data is kept.
module pswd_digit_shift
    import pswd_update_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              clr_i,
    input  logic              load_i,
    input  logic [DIG_W-1:0]  digit_i,
    output logic [DATA_W-1:0] data_o,
    output logic              full_o
);
    logic [DATA_W-1:0] data_q;
    logic [2:0]        cnt_q;
    logic              accept_s;

    assign accept_s = load_i && is_bcd(digit_i);
    assign full_o   = accept_s && (cnt_q == 3'd5);
    assign data_o   = data_q;

    // Shift accepted digits in from the right and count them.
    always_ff @(posedge clk) begin
        if (rst || clr_i) begin
            data_q <= '0;
            cnt_q  <= 3'd0;
        end else if (accept_s) begin
            data_q <= {data_q[DATA_W-DIG_W-1:0], digit_i};
            cnt_q  <= (cnt_q == 3'd5) ? 3'd0 : cnt_q + 3'd1;
        end else begin
            data_q <= data_q;
            cnt_q  <= cnt_q;
        end
    end
endmodule

// File: rtl/pswd_update.sv
// Password-store writer: takes a new 6-digit password twice from a logged-in
// non-guest player and, when both entries match, writes it to the password
// memory with a one-cycle strobe. All outputs are registered.
// Optional macro PSWD_UPDATE_TIMEOUT_EN: abort digit entry after TIMEOUT_CYC
// idle cycles.
module pswd_update
    import pswd_update_pkg::*;
#(
    parameter int ADDR_W      = 5,
    parameter int WR_HOLD     = 2,
    parameter int TIMEOUT_CYC = 1000
) (
    input logic           clk,
    input logic           rst,
    pswd_update_if.slave  bus
);
    localparam int HOLD_W = (WR_HOLD > 1) ? $clog2(WR_HOLD) : 1;

    state_e            state_q, state_d;
    logic [ID_W-1:0]   id_q, id_d;
    logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
    logic              wr_en_q, wr_en_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0] wr_data_q, wr_data_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic [1:0]        err_code_q, err_code_d;

    logic              clr_s, new_load_s, conf_load_s, new_full_s, conf_full_s, tmo_hit_s;
    logic [DATA_W-1:0] new_data_s, conf_data_s;

    // Digits only go to the buffer of the current entry phase.
    assign new_load_s  = (state_q == S_NEW_DIG)  && bus.UserLoad && bus.LoggedIn;
    assign conf_load_s = (state_q == S_CONF_DIG) && bus.UserLoad && bus.LoggedIn;

    pswd_digit_shift u_new (
        .clk(clk), .rst(rst), .clr_i(clr_s), .load_i(new_load_s),
        .digit_i(bus.UserDigit), .data_o(new_data_s), .full_o(new_full_s)
    );

    pswd_digit_shift u_conf (
        .clk(clk), .rst(rst), .clr_i(clr_s), .load_i(conf_load_s),
        .digit_i(bus.UserDigit), .data_o(conf_data_s), .full_o(conf_full_s)
    );

`ifdef PSWD_UPDATE_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic             in_entry_s, digit_acc_s;

    assign in_entry_s  = (state_q == S_NEW_DIG) || (state_q == S_CONF_DIG);
    assign digit_acc_s = (new_load_s || conf_load_s) && is_bcd(bus.UserDigit);
    assign tmo_hit_s   = in_entry_s && !digit_acc_s && (tmo_q == TMO_W'(TIMEOUT_CYC - 1));

    // Idle counter restarts on state entry and on every accepted digit.
    always_comb begin
        tmo_d = '0;
        if (state_d != state_q) begin
            tmo_d = '0;
        end else if (digit_acc_s) begin
            tmo_d = '0;
        end else if (in_entry_s) begin
            tmo_d = tmo_q + 1'b1;
        end else begin
            tmo_d = '0;
        end
    end

    // Idle counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            tmo_q <= '0;
        end else begin
            tmo_q <= tmo_d;
        end
    end
`else
    logic unused_tmo_s;
    assign unused_tmo_s = (TIMEOUT_CYC > 0);
    assign tmo_hit_s    = 1'b0;
`endif

    // Next-state logic, buffer clears and failure reporting.
    always_comb begin
        state_d    = state_q;
        id_d       = id_q;
        hold_cnt_d = hold_cnt_q;
        clr_s      = 1'b0;
        err_d      = 1'b0;
        err_code_d = 2'b00;
        case (state_q)
            S_IDLE: begin
                if (bus.change_req && bus.LoggedIn) begin
                    id_d  = bus.PlayerID_internal;
                    clr_s = 1'b1;
                    if (bus.isGuest) begin
                        state_d    = S_REJECT;
                        err_d      = 1'b1;
                        err_code_d = ERR_GUEST;
                    end else begin
                        state_d = S_NEW_DIG;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_REJECT: begin
                state_d = S_IDLE;
            end
            S_NEW_DIG, S_CONF_DIG: begin
                if (!bus.LoggedIn || tmo_hit_s) begin
                    state_d    = S_IDLE;
                    clr_s      = 1'b1;
                    err_d      = 1'b1;
                    err_code_d = ERR_ABORT;
                end else if ((state_q == S_NEW_DIG) && new_full_s) begin
                    state_d = S_CONF_DIG;
                end else if ((state_q == S_CONF_DIG) && conf_full_s) begin
                    state_d = S_COMPARE;
                end else begin
                    state_d = state_q;
                end
            end
            S_COMPARE: begin
                if (!bus.LoggedIn) begin
                    state_d    = S_IDLE;
                    clr_s      = 1'b1;
                    err_d      = 1'b1;
                    err_code_d = ERR_ABORT;
                end else if (new_data_s == conf_data_s) begin
                    state_d = S_WRITE;
                end else begin
                    state_d    = S_NEW_DIG;
                    clr_s      = 1'b1;
                    err_d      = 1'b1;
                    err_code_d = ERR_MISMATCH;
                end
            end
            S_WRITE: begin
                state_d    = S_HOLD;
                hold_cnt_d = '0;
            end
            S_HOLD: begin
                if (hold_cnt_q == HOLD_W'(WR_HOLD - 1)) begin
                    state_d    = S_DONE;
                    hold_cnt_d = '0;
                end else begin
                    hold_cnt_d = hold_cnt_q + 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                clr_s   = 1'b1;
            end
            default: begin
                state_d = S_IDLE;
                clr_s   = 1'b1;
            end
        endcase
    end

    // Output values for the upcoming state; the write port keeps its last value.
    always_comb begin
        wr_en_d   = (state_d == S_WRITE);
        busy_d    = (state_d != S_IDLE);
        done_d    = (state_d == S_DONE);
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        if (state_d == S_WRITE) begin
            wr_addr_d = ADDR_W'(pswd_addr(id_q));
            wr_data_d = new_data_s;
        end else begin
            wr_addr_d = wr_addr_q;
            wr_data_d = wr_data_q;
        end
    end

    // State, latched ID and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            id_q       <= '0;
            hold_cnt_q <= '0;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            err_code_q <= 2'b00;
        end else begin
            state_q    <= state_d;
            id_q       <= id_d;
            hold_cnt_q <= hold_cnt_d;
            wr_en_q    <= wr_en_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
            err_code_q <= err_code_d;
        end
    end

    assign bus.wr_en    = wr_en_q;
    assign bus.wr_addr  = wr_addr_q;
    assign bus.wr_data  = wr_data_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.err      = err_q;
    assign bus.err_code = err_code_q;
endmodule

// File: tb/tb_pswd_update.sv
// Scoreboard bench for pswd_update: stimulus pushes expected write/done/err
// events, a negedge monitor pops and compares them as the DUT raises them.
module tb_pswd_update;
    import pswd_update_pkg::*;

    localparam int WR_HOLD = 2;
    localparam int K_ERR = 0, K_WR = 1, K_DONE = 2;

    typedef struct {
        int          kind;
        logic [1:0]  code;
        logic [4:0]  addr;
        logic [23:0] data;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    pswd_update_if #(.ADDR_W(5)) bus();

    pswd_update #(.ADDR_W(5), .WR_HOLD(WR_HOLD), .TIMEOUT_CYC(20)) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   last_load_cyc = 0;
    int   wr_cyc = 0;
    logic busy_chk_pending = 1'b0;
    logic [4:0]  last_wr_addr = 5'd0;
    logic [23:0] last_wr_data = 24'd0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, want);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: pop and compare on every wr_en / done / err the DUT presents.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (!rst) begin
            if (busy_chk_pending) begin
                chk("busy_after_done", {31'd0, bus.busy}, 32'd0);
                busy_chk_pending <= 1'b0;
            end
            if (bus.wr_en) begin
                if (exp_q.size() == 0) chk("unexpected_wr_en", 32'd1, 32'd0);
                else begin
                    e = exp_q.pop_front();
                    chk("wr_kind", e.kind, K_WR);
                    chk("wr_addr", {27'd0, bus.wr_addr}, {27'd0, e.addr});
                    chk("wr_data", {8'd0, bus.wr_data}, {8'd0, e.data});
                    chk("wr_latency", cyc - last_load_cyc, 2);
                    wr_cyc       <= cyc;
                    last_wr_addr <= e.addr;
                    last_wr_data <= e.data;
                end
            end
            if (bus.done) begin
                if (exp_q.size() == 0) chk("unexpected_done", 32'd1, 32'd0);
                else begin
                    e = exp_q.pop_front();
                    chk("done_kind", e.kind, K_DONE);
                    chk("done_latency", cyc - wr_cyc, WR_HOLD + 1);
                    chk("held_wr_addr", {27'd0, bus.wr_addr}, {27'd0, last_wr_addr});
                    chk("held_wr_data", {8'd0, bus.wr_data}, {8'd0, last_wr_data});
                    chk("busy_with_done", {31'd0, bus.busy}, 32'd1);
                    busy_chk_pending <= 1'b1;
                end
            end
            if (bus.err) begin
                if (exp_q.size() == 0) chk("unexpected_err", {30'd0, bus.err_code}, 32'd0);
                else begin
                    e = exp_q.pop_front();
                    chk("err_kind", e.kind, K_ERR);
                    chk("err_code", {30'd0, bus.err_code}, {30'd0, e.code});
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_err(input logic [1:0] code);
        exp_t e;
        e.kind = K_ERR; e.code = code; e.addr = 5'd0; e.data = 24'd0;
        exp_q.push_back(e);
    endtask

    task automatic push_wr(input logic [4:0] addr, input logic [23:0] data);
        exp_t e;
        e.kind = K_WR; e.code = 2'b00; e.addr = addr; e.data = data;
        exp_q.push_back(e);
        e.kind = K_DONE;
        exp_q.push_back(e);
    endtask

    task automatic start(input logic [2:0] id);
        bus.PlayerID_internal = id;
        bus.change_req = 1'b1;
        tick();
        bus.change_req = 1'b0;
    endtask

    task automatic digit(input logic [3:0] d);
        bus.UserLoad  = 1'b1;
        bus.UserDigit = d;
        last_load_cyc = cyc;
        tick();
        bus.UserLoad  = 1'b0;
    endtask

    task automatic send6(input logic [23:0] w);
        for (int i = 0; i < 6; i++) digit(w[(5 - i) * 4 +: 4]);
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < 60) begin
            tick();
            n++;
        end
        if (exp_q.size() != 0) begin
            chk({name, "_timeout"}, exp_q.size(), 32'd0);
            exp_q.delete();
        end
        tick();
    endtask

    initial begin
        logic [3:0] ent_f[7];
        logic [3:0] conf_f[7];
        ent_f  = '{4'hA, 4'h9, 4'h8, 4'h7, 4'h6, 4'h5, 4'h4};
        conf_f = '{4'h9, 4'h8, 4'hF, 4'h7, 4'h6, 4'h5, 4'h4};

        rst = 1'b1;
        bus.LoggedIn = 1'b0; bus.PlayerID_internal = 3'd0; bus.isGuest = 1'b0;
        bus.change_req = 1'b0; bus.UserLoad = 1'b0; bus.UserDigit = 4'd0;
        tick();
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("rst_wr_en",    {31'd0, bus.wr_en}, 32'd0);
        chk("rst_busy",     {31'd0, bus.busy},  32'd0);
        chk("rst_done",     {31'd0, bus.done},  32'd0);
        chk("rst_err",      {31'd0, bus.err},   32'd0);
        chk("rst_err_code", {30'd0, bus.err_code}, 32'd0);
        chk("rst_wr_addr",  {27'd0, bus.wr_addr}, 32'd0);
        chk("rst_wr_data",  {8'd0, bus.wr_data},  32'd0);
        tick();

        // Basic change for player 3; ID change and change_req while busy ignored.
        bus.LoggedIn = 1'b1;
        push_wr(5'd3, 24'h123456);
        start(3'd3);
        bus.PlayerID_internal = 3'd6;
        bus.change_req = 1'b1;
        tick();
        bus.change_req = 1'b0;
        send6(24'h123456);
        send6(24'h123456);
        wait_drain("basic");

        // Guest rejected one cycle after the request.
        bus.isGuest = 1'b1;
        push_err(ERR_GUEST);
        start(3'd4);
        @(negedge clk);
        chk("guest_err_latency", {31'd0, bus.err}, 32'd1);
        wait_drain("guest");
        bus.isGuest = 1'b0;

        // Mismatch, then retry without a new request.
        push_err(ERR_MISMATCH);
        start(3'd2);
        send6(24'h111111);
        send6(24'h111112);
        wait_drain("mismatch");
        @(negedge clk);
        chk("retry_busy", {31'd0, bus.busy}, 32'd1);
        push_wr(5'd2, 24'h222222);
        send6(24'h222222);
        send6(24'h222222);
        wait_drain("retry");

        // Non-decimal digits are ignored.
        push_wr(5'd5, 24'h987654);
        start(3'd5);
        for (int i = 0; i < 7; i++) digit(ent_f[i]);
        for (int i = 0; i < 7; i++) digit(conf_f[i]);
        wait_drain("filter");

        // Abort after the 3rd confirm digit, then a clean restart.
        push_err(ERR_ABORT);
        start(3'd7);
        send6(24'h135790);
        digit(4'd1); digit(4'd3); digit(4'd5);
        bus.LoggedIn = 1'b0;
        tick();
        bus.LoggedIn = 1'b1;
        wait_drain("abort");
        push_wr(5'd7, 24'h246802);
        start(3'd7);
        send6(24'h246802);
        send6(24'h246802);
        wait_drain("after_abort");

        // Inactivity in NEW_DIG.
`ifdef PSWD_UPDATE_TIMEOUT_EN
        push_err(ERR_ABORT);
        start(3'd1);
        repeat (25) tick();
        wait_drain("timeout");
        @(negedge clk);
        chk("timeout_busy", {31'd0, bus.busy}, 32'd0);
        tick();
`else
        start(3'd1);
        repeat (25) tick();
        @(negedge clk);
        chk("no_timeout_busy", {31'd0, bus.busy}, 32'd1);
        tick();
        push_err(ERR_ABORT);
        bus.LoggedIn = 1'b0;
        tick();
        bus.LoggedIn = 1'b1;
        wait_drain("exit_wait");
`endif

        // Request while logged out is ignored.
        bus.LoggedIn = 1'b0;
        start(3'd1);
        @(negedge clk);
        chk("logged_out_busy", {31'd0, bus.busy}, 32'd0);
        tick();

        repeat (5) tick();
        chk("queue_empty", exp_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/pswd_update.md
Name: pswd_update

Overview:
- Password-store writer; the counterpart of the login checker that reads the 24-bit password ROM/RAM.
- A logged-in, non-guest player enters a new 6-digit password twice (entry, then confirm).
- On a match, the block writes the new password to the password memory at the player's address with a single-cycle write strobe.
- Sits beside the login FSM, sharing UserLoad/UserDigit and the password memory's write port.

Parameters:
ADDR_W, 5, password memory address width
DATA_W, 24, password width (6 BCD digits x 4 bits)
WR_HOLD, 2, busy cycles after the write strobe, covering memory write latency
TIMEOUT_CYC, 1000, inactivity limit in cycles (used only with the optional feature)

Ports:
clk  in  1  system clock
rst  in  1  reset: synchronous, active-high
LoggedIn  in  1  login FSM reports the player is authenticated
PlayerID_internal  in  3  authenticated player ID
isGuest  in  1  authenticated player is a guest
change_req  in  1  single-cycle request to start a password change
UserLoad  in  1  single-cycle digit strobe
UserDigit  in  4  digit value
wr_en  out  1  password memory write strobe
wr_addr  out  ADDR_W  write address
wr_data  out  DATA_W  write data
busy  out  1  high in every state except IDLE
done  out  1  single-cycle success pulse
err  out  1  single-cycle failure pulse
err_code  out  2  cause of failure, valid while err=1: 01 guest, 10 mismatch, 11 abort/timeout

Behaviour:
- Reset (rst=1 at posedge): state IDLE. All outputs 0. Both digit buffers, the digit counter and the latched ID cleared.
- States: IDLE, NEW_DIG, CONF_DIG, COMPARE, WRITE, HOLD, DONE, REJECT.
- IDLE:
  - change_req=1 and LoggedIn=1: latch PlayerID_internal and go to NEW_DIG if isGuest=0, else REJECT.
  - change_req with LoggedIn=0: ignored.
- REJECT: err=1, err_code=01 for one cycle, then IDLE.
- NEW_DIG / CONF_DIG:
  - Each UserLoad with UserDigit <= 9 stores the digit MSB-first (first digit to [23:20], sixth to [3:0]) and increments the 3-bit counter.
  - UserDigit > 9: ignored, no advance.
  - The sixth digit moves NEW_DIG to CONF_DIG, or CONF_DIG to COMPARE, and clears the counter.
- COMPARE (1 cycle):
  - Buffers equal: go to WRITE.
  - Not equal: err=1, err_code=10 for one cycle. Clear both buffers and go to NEW_DIG (retry without a new change_req).
- WRITE (1 cycle): wr_en=1, wr_addr={2'b00, latched ID}, wr_data=new buffer. Go to HOLD.
- HOLD: count WR_HOLD cycles, then go to DONE. wr_addr and wr_data hold their values; wr_en=0.
- DONE: done=1 for one cycle. Clear buffers; go to IDLE.
- Latency: the 6th confirm UserLoad is accepted at cycle N; COMPARE at N+1; wr_en at N+2; done at N+3+WR_HOLD.
- Abort: LoggedIn=0 in NEW_DIG, CONF_DIG or COMPARE goes to IDLE next cycle with err=1, err_code=11, and no write. From WRITE onward the sequence always completes.
- change_req while busy=1 is ignored.
- UserLoad in IDLE/COMPARE/WRITE/HOLD/DONE is ignored.
- PlayerID_internal changes after the latch have no effect.
- rst mid-operation overrides everything. A write already issued is not retracted.

Optional Feature:
- Macro PSWD_UPDATE_TIMEOUT_EN.
- Defined: a counter runs in NEW_DIG/CONF_DIG, is cleared on each accepted digit and on state entry, and reaching TIMEOUT_CYC aborts to IDLE with err=1, err_code=11.
- Undefined: no counter; the block waits for digits indefinitely.

Decomposition:
- Shared package holds:
  - the state encoding;
  - the err_code constants ERR_GUEST=2'b01, ERR_MISMATCH=2'b10, ERR_ABORT=2'b11;
  - DATA_W and the digit width 4;
  - the password address mapping {2'b00, ID}, shared with the login checker.
- One natural sub-module, pswd_digit_shift: a 6-digit MSB-first loader with BCD filter, clear, and a "full" flag. It is instantiated twice (new and confirm buffers).

Test Plan:
- rst=1 for 2 cycles, then LoggedIn=1, ID=3, change_req, digits 1,2,3,4,5,6 twice -> wr_en single pulse with wr_addr=5'd3, wr_data=24'h123456; done exactly WR_HOLD+1 cycles after wr_en; busy drops with done.
- Guest path: LoggedIn=1, isGuest=1, change_req -> err=1, err_code=01 one cycle later; wr_en never asserts.
- Mismatch then retry: entry 111111, confirm 111112 -> err_code=10 pulse and state NEW_DIG. Then 222222 twice -> wr_data=24'h222222.
- Digit filter: UserDigit=4'hA interleaved in entry -> ignored. The 7 strobes A,9,8,7,6,5,4 then 9,8,7,6,5,4 -> wr_data=24'h987654.
- Abort: LoggedIn drops after the 3rd confirm digit -> err_code=11, no wr_en. A following change_req starts from clean buffers.
- With PSWD_UPDATE_TIMEOUT_EN, TIMEOUT_CYC=20: no UserLoad for 20 cycles in NEW_DIG -> err_code=11 and busy=0. Without the macro, busy stays high.
